// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, with a
// start/ready/done handshake and results held until the next accepted start.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] prem_q, prem_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   trial;
    logic          qbit;
    logic [VW-1:0] diff;
    logic [VW-1:0] prem_step;
    logic [DW-1:0] shreg_step;

    // The partial remainder is always below the divisor, so its extra bit is
    // only ever needed inside the trial value and is not stored.
    always_comb begin
        trial      = {prem_q, shreg_q[DW-1]};
        qbit       = (trial >= {1'b0, dvs_q});
        // The true difference fits VW bits whenever it is taken, so modulo
        // arithmetic on the low bits yields the exact result.
        diff       = trial[VW-1:0] - dvs_q;
        prem_step  = qbit ? diff : trial[VW-1:0];
        shreg_step = {shreg_q[DW-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvs_d   = divisor;
                    shreg_d = dividend;
                    prem_d  = '0;
                    if (divisor == '0) begin
                        cnt_d  = '0;
                        quot_d = '1;
                        rem_d  = '1;
                        dbz_d  = 1'b1;
                    end else begin
                        cnt_d  = CW'(DW);
                        dbz_d  = 1'b0;
                    end
                end
            end
            S_CALC: begin
                prem_d  = prem_step;
                shreg_d = shreg_step;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d = shreg_step;
                    rem_d  = prem_step;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        ready       = (state_q == S_IDLE);
        busy        = (state_q == S_CALC);
        done        = (state_q == S_DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at DW=8, VW=4.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check_eq("ready_before_start", 32'(ready), 32'd1);
    endtask

    // Pulses start in the current IDLE cycle (cycle 0), checks done latency,
    // results, and that results stay held in the following IDLE cycle.
    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                          input logic [7:0] exp_q, input logic [3:0] exp_r,
                          input logic exp_dbz, input int exp_lat);
        int n;
        wait_ready();
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        check_eq({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
        check_eq({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        tick();
        dividend = ~dvd;
        divisor  = ~dvs;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_held"}, {19'd0, div_by_zero, remainder, quotient},
                 {19'd0, exp_dbz, exp_r, exp_q});
    endtask

    initial begin
        int  n;
        bit  saw_done;
        logic [7:0] a8;
        logic [7:0] eq;
        logic [3:0] er;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_quotient", 32'(quotient), 32'd0);
        check_eq("rst_remainder", 32'(remainder), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);

        run_op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9);
        run_op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9);
        run_op("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 9);
        run_op("d0_3", 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, 9);
        run_op("dz_55", 8'h55, 4'd0, 8'hFF, 4'hF, 1'b1, 1);
        run_op("d100_10", 8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 9);

        // Requests during CALC and DONE must be ignored.
        wait_ready();
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; dividend = 8'd15; divisor = 4'd3;
        tick();
        start = 1'b0;
        check_eq("busy_c4", 32'(busy), 32'd1);
        tick(); tick(); tick(); tick(); tick();
        check_eq("busy_ign_done_c9", 32'(done), 32'd1);
        check_eq("busy_ign_q", 32'(quotient), 32'd28);
        check_eq("busy_ign_r", 32'(remainder), 32'd4);
        start = 1'b1; dividend = 8'd15; divisor = 4'd3;
        tick();
        check_eq("busy_ign_c10_ready", 32'(ready), 32'd1);
        check_eq("busy_ign_c10_q", 32'(quotient), 32'd28);
        tick();
        start = 1'b0;
        check_eq("reissue_busy", 32'(busy), 32'd1);
        n = 11;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check_eq("reissue_done_cycle", 32'(n), 32'd19);
        check_eq("reissue_q", 32'(quotient), 32'd5);
        check_eq("reissue_r", 32'(remainder), 32'd0);
        tick();

        // Reset in the middle of a calculation.
        wait_ready();
        start = 1'b1; dividend = 8'd255; divisor = 4'd2;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_ready", 32'(ready), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_outs", {19'd0, div_by_zero, remainder, quotient}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check_eq("midrst_no_done", 32'(saw_done), 32'd0);
        run_op("d255_2", 8'd255, 4'd2, 8'd127, 4'd1, 1'b0, 9);

        // Reset and start together: the request is lost.
        rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 4'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check_eq("rst_start_ready", 32'(ready), 32'd1);
        check_eq("rst_start_busy", 32'(busy), 32'd0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                a8 = 8'(a * b);
                run_op("roundtrip", a8, 4'(b), 8'(a), 4'd0, 1'b0, 9);
            end
        end

        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 16; y++) begin
                if (y == 0) begin
                    eq = 8'hFF;
                    er = 4'hF;
                end else begin
                    eq = 8'(x / y);
                    er = 4'(x % y);
                end
                run_op("sweep", 8'(x), 4'(y), eq, er, (y == 0), (y == 0) ? 1 : 9);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring unsigned divider; the inverse operation of the team's combinational 4x4 multiplier.
- Divides a DW-bit dividend by a VW-bit divisor, producing one quotient bit per clock.
- Sits beside the multiplier in the same tiny-tile datapath; a valid product r = a*b with b != 0 must round-trip through it as dividend r, divisor b, giving quotient a and remainder 0.
- Start/ready/done handshake; results held stable until the next accepted start.

Parameters:
- DW, 8, dividend and quotient width in bits.
- VW, 4, divisor and remainder width in bits (VW <= DW).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only when ready=1.
- dividend  input  DW  numerator, sampled in the start-accept cycle.
- divisor  input  VW  denominator, sampled in the start-accept cycle.
- ready  output  1  high in IDLE only.
- busy  output  1  high in CALC only.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  DW  result, held after done.
- remainder  output  VW  result, held after done.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-CALC: state=IDLE, counter=0, internal registers cleared, ready=1, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- States: IDLE, CALC, DONE.
- IDLE with start=1:
  - Latch dividend and divisor.
  - If divisor==0: go to DONE; quotient=all ones, remainder=all ones, div_by_zero=1.
  - Otherwise: go to CALC; partial remainder (VW+1 bits)=0; shift register=dividend; counter=DW; div_by_zero=0.
- IDLE with start=0: stay in IDLE.
- CALC step, one per cycle:
  - trial = {partial remainder[VW-1:0], shift register MSB}.
  - If trial >= {0,divisor}: partial remainder = trial - divisor, quotient bit = 1.
  - Else: partial remainder = trial, quotient bit = 0.
  - Shift register shifts left and takes the quotient bit into its LSB.
  - Counter decrements.
  - When the step with counter==1 completes, go to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
  - quotient/remainder are registered on entry to DONE and held until the next accepted start.
  - The next accepted start changes them only when its own DONE is entered.
- Latency: start accepted at cycle 0 -> CALC in cycles 1..DW -> done=1 in cycle DW+1 (cycle 9 at defaults). Divide-by-zero: done=1 in cycle 1.
- Throughput: a new start is accepted in the cycle after DONE, i.e. the first IDLE cycle.
- start while busy=1 or in the DONE cycle: ignored; no effect on the operation in flight or on the held operands.
- Operand inputs may change freely outside the accept cycle.
- Arithmetic:
  - Unsigned only.
  - The partial remainder never exceeds VW bits after subtraction, so remainder < divisor always.
  - quotient*divisor + remainder == dividend for divisor != 0.
- Reset and start both high in the same cycle: reset wins; the request is lost.

Test Plan:
- Reset: hold rst=1 for 2 cycles, release -> ready=1, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Normal cases at defaults, start pulsed 1 cycle -> done exactly at cycle 9, results held thereafter:
  - dividend=200, divisor=7 -> quotient=28, remainder=4.
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 0/3 -> quotient=0, remainder=0.
- Divide by zero: dividend=0x55, divisor=0 -> done at cycle 1, quotient=0xFF, remainder=0xF, div_by_zero=1. A following 100/10 -> quotient=10, remainder=0, div_by_zero=0.
- Start while busy: start 200/7, then assert start with 15/3 in cycles 3 and 9 -> only 28 r4 is produced. The second request is accepted only when reissued in cycle 10.
- Reset mid-operation: start 255/2, assert rst in cycle 4 -> IDLE next cycle, all outputs 0, no done pulse. Then 255/2 -> quotient=127, remainder=1.
- Round trip with the multiplier: for all a in 0..15 and b in 1..15, dividend=a*b, divisor=b -> quotient=a, remainder=0. Exhaustive random sweep over all 256 x 16 pairs vs a reference model.
